// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets several drawing engines share one synchronous single-port frame RAM.
// Read data goes back on a shared bus, with a one-cycle strobe that marks the owning client.
module mem_arbiter #(
    parameter int unsigned NUM_CLIENTS  = 2,
    parameter int unsigned CLIENT_IDX_W = 1,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [NUM_CLIENTS*32-1:0] cli_data,
    input  logic [NUM_CLIENTS*16-1:0] cli_addr,
    input  logic [NUM_CLIENTS*4-1:0]  cli_wben,
    input  logic [NUM_CLIENTS-1:0]    cli_op,
    input  logic [NUM_CLIENTS-1:0]    cli_rts,
    output logic [NUM_CLIENTS-1:0]    cli_rtr,
    output logic [31:0]               bcast_data,
    output logic [NUM_CLIENTS-1:0]    bcast_xfc,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [15:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wben,
    input  logic [31:0]               mem_rdata
);

    logic [CLIENT_IDX_W-1:0] ptr_q, ptr_d;
    logic [CLIENT_IDX_W-1:0] gnt_idx, cand;
    logic                    found;
    logic                    xfer;
    logic [NUM_CLIENTS-1:0]  grant;

    logic        sel_op;
    logic [15:0] sel_addr;
    logic [31:0] sel_data;
    logic [3:0]  sel_wben;

    // Read tags: stage 0 lines up with mem_en, stage RD_LAT with valid mem_rdata.
    logic [RD_LAT:0]         tag_vld_q;
    logic [CLIENT_IDX_W-1:0] tag_idx_q [RD_LAT+1];

    // Scan from the pointer, wrapping, and take the first requester.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        grant   = '0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            cand = CLIENT_IDX_W'((32'(ptr_q) + k) % NUM_CLIENTS);
            if (!found && cli_rts[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        xfer = found & ~rst_;
        if (xfer) begin
            grant[gnt_idx] = 1'b1;
        end
        ptr_d = xfer ? CLIENT_IDX_W'((32'(gnt_idx) + 1) % NUM_CLIENTS) : ptr_q;
    end

    assign cli_rtr  = grant;
    assign sel_op   = cli_op[gnt_idx];
    assign sel_addr = cli_addr[32'(gnt_idx)*16 +: 16];
    assign sel_data = cli_data[32'(gnt_idx)*32 +: 32];
    assign sel_wben = cli_wben[32'(gnt_idx)*4 +: 4];

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            ptr_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wben  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            mem_en <= xfer;
            if (xfer) begin
                mem_we    <= sel_op;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_data;
                mem_wben  <= sel_op ? sel_wben : 4'b0000;
            end else begin
                mem_we   <= 1'b0;
                mem_wben <= 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            tag_vld_q <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
            bcast_data <= '0;
            bcast_xfc  <= '0;
        end else begin
            tag_vld_q    <= {tag_vld_q[RD_LAT-1:0], xfer & ~sel_op};
            tag_idx_q[0] <= gnt_idx;
            for (int s = 1; s <= RD_LAT; s++) begin
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
            bcast_xfc <= '0;
            if (tag_vld_q[RD_LAT]) begin
                bcast_data                   <= mem_rdata;
                bcast_xfc[tag_idx_q[RD_LAT]] <= 1'b1;
            end
        end
    end

endmodule
